// File: rtl/dma_xfer_ctrl_pkg.sv
// Shared definitions for the DMA transfer engine: FSM state encoding and default limits.
package dma_xfer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } dma_state_e;

    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_TIMEOUT   = 255;
    localparam int WD_W          = 8;

    // States in which the engine holds (or wants) the bus.
    function automatic logic is_bus_state(input dma_state_e s);
        return (s == ST_REQ) || (s == ST_READ) || (s == ST_WRITE);
    endfunction

    function automatic logic is_busy_state(input dma_state_e s);
        return is_bus_state(s) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/dma_xfer_ctrl_addr_cnt.sv
// Source/destination address incrementers plus remaining-word and burst down-counters.
// Exposes next-cycle addresses so the top can register mem_addr without a cycle of lag.
module dma_xfer_ctrl_addr_cnt #(
    parameter int AW        = 16,
    parameter int LW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic          reload_burst,
    input  logic [AW-1:0] src_init,
    input  logic [AW-1:0] dst_init,
    input  logic [LW-1:0] len_init,
    output logic [AW-1:0] src_nxt,
    output logic [AW-1:0] dst_nxt,
    output logic          last_word,
    output logic          burst_end
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_INIT = BW'(BURST_LEN);

    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] rem_q;
    logic [LW-1:0] rem_nxt;
    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_nxt;

    always_comb begin
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        rem_nxt   = rem_q;
        burst_nxt = burst_q;
        if (load) begin
            src_nxt   = src_init;
            dst_nxt   = dst_init;
            rem_nxt   = len_init;
            burst_nxt = BURST_INIT;
        end else begin
            // Addresses wrap silently at 2^AW.
            if (step) begin
                src_nxt   = src_q + AW'(1);
                dst_nxt   = dst_q + AW'(1);
                rem_nxt   = rem_q - LW'(1);
                burst_nxt = burst_q - BW'(1);
            end
            if (reload_burst) begin
                burst_nxt = BURST_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            burst_q <= '0;
        end else begin
            src_q   <= src_nxt;
            dst_q   <= dst_nxt;
            rem_q   <= rem_nxt;
            burst_q <= burst_nxt;
        end
    end

    // Flags describe the word currently in flight, i.e. before its step.
    assign last_word = (rem_q == LW'(1));
    assign burst_end = (burst_q == BW'(1));

endmodule

// File: rtl/dma_xfer_ctrl.sv
// DMA block-copy engine in front of the DMA/TDSP arbiter; releases the bus every BURST_LEN words.
// Optional mem_ready watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_xfer_ctrl
    import dma_xfer_ctrl_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int LW        = 8,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] xfer_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          dma_breq,
    input  logic          dma_grant,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    // Memory handshake: a strobe (mem_rd or mem_wr) with its address/data is held
    // unchanged until a rising edge samples mem_ready=1; that edge completes the access.
    // A strobe is only ever presented while dma_grant=1.

    dma_state_e state_q;
    dma_state_e state_d;

    logic          load;
    logic          step;
    logic          reload_burst;
    logic          capture;
    logic          zero_done;
    logic          abort;
    logic          wd_hit;
    logic [AW-1:0] src_nxt;
    logic [AW-1:0] dst_nxt;
    logic          last_word;
    logic          burst_end;

    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          breq_q;
    logic          rd_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    dma_xfer_ctrl_addr_cnt #(
        .AW        (AW),
        .LW        (LW),
        .BURST_LEN (BURST_LEN)
    ) u_addr_cnt (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .step         (step),
        .reload_burst (reload_burst),
        .src_init     (src_addr),
        .dst_init     (dst_addr),
        .len_init     (xfer_len),
        .src_nxt      (src_nxt),
        .dst_nxt      (dst_nxt),
        .last_word    (last_word),
        .burst_end    (burst_end)
    );

`ifdef DMA_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q;

    assign wd_hit = ((state_q == ST_READ) || (state_q == ST_WRITE)) && !mem_ready
                    && (wd_q == WD_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (((state_q == ST_READ) || (state_q == ST_WRITE)) && !mem_ready && !wd_hit) begin
            wd_q <= wd_q + WD_W'(1);
        end else begin
            wd_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign wd_hit         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        step         = 1'b0;
        reload_burst = 1'b0;
        capture      = 1'b0;
        zero_done    = 1'b0;
        abort        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (xfer_len != '0) begin
                        load    = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (dma_grant) state_d = ST_READ;
            end
            // Losing the grant mid-access restarts the current word from its read.
            ST_READ: begin
                if (!dma_grant) begin
                    state_d = ST_REQ;
                end else if (mem_ready) begin
                    capture = 1'b1;
                    state_d = ST_WRITE;
                end else if (wd_hit) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!dma_grant) begin
                    state_d = ST_REQ;
                end else if (mem_ready) begin
                    step = 1'b1;
                    if (last_word)      state_d = ST_DONE;
                    else if (burst_end) state_d = ST_RELEASE;
                    else                state_d = ST_READ;
                end else if (wd_hit) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                reload_burst = 1'b1;
                state_d      = ST_REQ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            breq_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= is_busy_state(state_d);
            done_q  <= (state_d == ST_DONE) || zero_done;
            err_q   <= abort;
            breq_q  <= is_bus_state(state_d);
            rd_q    <= (state_d == ST_READ);
            wr_q    <= (state_d == ST_WRITE);
            if (state_d == ST_READ) begin
                addr_q <= src_nxt;
            end else if (state_d == ST_WRITE) begin
                addr_q <= dst_nxt;
            end
            if (capture) begin
                wdata_q <= mem_rdata;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dma_breq  = breq_q;
    // Gated so no strobe survives a grant loss, even within the cycle it happens.
    assign mem_rd    = rd_q & dma_grant;
    assign mem_wr    = wr_q & dma_grant;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
